vga_scan_controller: RTL and testbench

Pixel-scan initiator for the Tetris VGA path. It runs the 640x480@60 Hz raster counters and issues the linear pixel address `ADDR` to the field-display colour lookup. It registers the returned 24-bit BGR colour onto the DAC pins with aligned sync and blank signals. It also double-buffers the 400-bit game field, so the game logic can update at any time without tearing a displayed frame.

---
 rtl/vga_scan_controller.sv | 128 ++++++++++++
 tb/tb_vga_scan_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// VGA raster scan controller: 640x480@60 timing counters, linear pixel address, registered
// DAC outputs with aligned sync/blank, and a per-frame double buffer for the game field.
module vga_scan_controller #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33
) (
   input  logic         clk,
   input  logic         reset,
   output logic [18:0]  ADDR,
   input  logic [23:0]  bgr_data_raw,
   input  logic [399:0] field_next,
   output logic [399:0] field,
   output logic         frame_done,
   output logic [7:0]   VGA_R,
   output logic [7:0]   VGA_G,
   output logic [7:0]   VGA_B,
   output logic         VGA_HS,
   output logic         VGA_VS,
   output logic         VGA_BLANK_N,
   output logic         VGA_CLK
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END    = HW'(H_VISIBLE);
   localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_VISIBLE + H_FP);
   localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_END    = VW'(V_VISIBLE);
   localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_VISIBLE + V_FP);
   localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [HW-1:0] hcnt, hcnt_d;
   logic [VW-1:0] vcnt, vcnt_d;
   logic [18:0]   addr_d;
   logic          h_wrap;
   logic          visible;
   logic          visible_d;
   logic          frame_start_d;
   logic          vblank_start_d;
   logic          hs_d;
   logic          vs_d;

   assign VGA_CLK = clk;

   // Next raster position; address and field decisions look at where the scan is going.
   always_comb begin
      h_wrap = (hcnt == H_LAST);
      hcnt_d = h_wrap ? '0 : hcnt + HW'(1);
      vcnt_d = vcnt;
      if (h_wrap) begin
         vcnt_d = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
      end
   end

   always_comb begin
      visible        = (hcnt < H_VIS_END) && (vcnt < V_VIS_END);
      visible_d      = (hcnt_d < H_VIS_END) && (vcnt_d < V_VIS_END);
      frame_start_d  = (hcnt_d == '0) && (vcnt_d == '0);
      vblank_start_d = (hcnt_d == '0) && (vcnt_d == V_VIS_END);
      hs_d           = !((hcnt >= H_SYNC_FIRST) && (hcnt <= H_SYNC_LAST));
      vs_d           = !((vcnt >= V_SYNC_FIRST) && (vcnt <= V_SYNC_LAST));
   end

   // Address walks by increment only, holding through blanking.
   always_comb begin
      addr_d = ADDR;
      if (frame_start_d) begin
         addr_d = '0;
      end else if (visible_d) begin
         addr_d = ADDR + 19'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt <= '0;
         vcnt <= '0;
         ADDR <= '0;
      end else begin
         hcnt <= hcnt_d;
         vcnt <= vcnt_d;
         ADDR <= addr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         field      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= vblank_start_d;
         if (vblank_start_d) begin
            field <= field_next;
         end
      end
   end

   // Colour is for the pixel at the current position, so it lands one cycle after ADDR.
   always_ff @(posedge clk) begin
      if (reset) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
      end else begin
         VGA_R       <= visible ? bgr_data_raw[7:0]   : 8'd0;
         VGA_G       <= visible ? bgr_data_raw[15:8]  : 8'd0;
         VGA_B       <= visible ? bgr_data_raw[23:16] : 8'd0;
         VGA_HS      <= hs_d;
         VGA_VS      <= vs_d;
         VGA_BLANK_N <= visible;
      end
   end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller using a shrunken raster so whole frames fit in a
// short run; an independent position model predicts every pin each cycle.
module tb_vga_scan_controller;

   localparam int HV  = 16;
   localparam int HFP = 2;
   localparam int HS  = 4;
   localparam int HBP = 3;
   localparam int VV  = 8;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 3;
   localparam int HT  = HV + HFP + HS + HBP;
   localparam int VT  = VV + VFP + VS + VBP;

   logic         clk;
   logic         reset;
   logic [18:0]  ADDR;
   logic [23:0]  bgr_data_raw;
   logic [399:0] field_next;
   logic [399:0] field;
   logic         frame_done;
   logic [7:0]   VGA_R, VGA_G, VGA_B;
   logic         VGA_HS, VGA_VS, VGA_BLANK_N, VGA_CLK;

   vga_scan_controller #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (
      .clk(clk), .reset(reset), .ADDR(ADDR), .bgr_data_raw(bgr_data_raw),
      .field_next(field_next), .field(field), .frame_done(frame_done),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_CLK(VGA_CLK)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      logic        blank_n;
   } exp_t;

   exp_t         sb[$];
   int           vectors = 0;
   int           miscompares = 0;
   int           mh = 0, mv = 0, maddr = 0;
   logic         mdone = 1'b0;
   logic [399:0] mfield = '0;
   int           cyc = 0;
   int           hs_run = 0, vs_run = 0, hs_fall = -1, vs_fall = -1;
   logic         hs_prev = 1'b1, vs_prev = 1'b1;
   logic [399:0] f2, f3;

   task automatic chk(input string tag, input logic [399:0] got, input logic [399:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [399:0] rand400();
      logic [399:0] r = '0;
      for (int i = 0; i < 13; i++) r = {r[367:0], 32'($urandom)};
      return r;
   endfunction

   task automatic step(input logic [23:0] bgr);
      exp_t         e;
      logic         r_now;
      logic         vis;
      logic [399:0] fn;
      bgr_data_raw = bgr;
      r_now = reset;
      fn = field_next;
      if (r_now) begin
         e = '{rgb: 24'd0, hs: 1'b1, vs: 1'b1, blank_n: 1'b0};
      end else begin
         vis = (mh < HV) && (mv < VV);
         e.rgb     = vis ? {bgr[7:0], bgr[15:8], bgr[23:16]} : 24'd0;
         e.hs      = !(mh >= HV + HFP && mh < HV + HFP + HS);
         e.vs      = !(mv >= VV + VFP && mv < VV + VFP + VS);
         e.blank_n = vis;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      if (r_now) begin
         mh = 0; mv = 0; maddr = 0; mfield = '0; mdone = 1'b0;
      end else begin
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else begin
            mh++;
         end
         mdone = (mh == 0) && (mv == VV);
         if (mdone) mfield = fn;
         if (mh < HV && mv < VV) maddr = mv * HV + mh;
      end
      e = sb.pop_front();
      chk("rgb", 400'({VGA_R, VGA_G, VGA_B}), 400'(e.rgb));
      chk("hs", 400'(VGA_HS), 400'(e.hs));
      chk("vs", 400'(VGA_VS), 400'(e.vs));
      chk("blank_n", 400'(VGA_BLANK_N), 400'(e.blank_n));
      chk("addr", 400'(ADDR), 400'(maddr));
      chk("frame_done", 400'(frame_done), 400'(mdone));
      chk("field", field, mfield);
      if (r_now) begin
         hs_run = 0; vs_run = 0; hs_fall = -1; vs_fall = -1;
      end else begin
         if (!VGA_HS) begin
            if (hs_prev) begin
               if (hs_fall >= 0) chk("hs_period", 400'(cyc - hs_fall), 400'(HT));
               hs_fall = cyc;
            end
            hs_run++;
         end else if (hs_run != 0) begin
            chk("hs_width", 400'(hs_run), 400'(HS));
            hs_run = 0;
         end
         if (!VGA_VS) begin
            if (vs_prev) begin
               if (vs_fall >= 0) chk("vs_period", 400'(cyc - vs_fall), 400'(HT * VT));
               vs_fall = cyc;
            end
            vs_run++;
         end else if (vs_run != 0) begin
            chk("vs_width", 400'(vs_run), 400'(VS * HT));
            vs_run = 0;
         end
      end
      hs_prev = VGA_HS;
      vs_prev = VGA_VS;
   endtask

   task automatic run_to(input int h, input int v);
      int n = 0;
      while (!(mh == h && mv == v) && n < 2 * HT * VT) begin
         step(24'($urandom));
         n++;
      end
      chk("run_to", 400'(mh * 1000 + mv), 400'(h * 1000 + v));
   endtask

   initial begin
      reset = 1'b1;
      bgr_data_raw = '0;
      field_next = rand400();
      step(24'($urandom));
      step(24'($urandom));
      reset = 1'b0;
      step(24'($urandom));
      chk("first_addr", 400'(ADDR), 400'(1));

      // Capture a field so the later mid-frame reset has something to clear.
      run_to(0, VV);
      chk("done_pulse0", 400'(frame_done), 400'(1));
      chk("field_cap0", field, field_next);

      run_to(7, 3);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(24'hffffff);
         chk("rst_addr", 400'(ADDR), 400'(0));
         chk("rst_rgb", 400'({VGA_R, VGA_G, VGA_B}), 400'(0));
         chk("rst_sync", 400'({VGA_HS, VGA_VS, VGA_BLANK_N}), 400'(3'b110));
         chk("rst_field", field, 400'(0));
      end
      reset = 1'b0;
      step(24'($urandom));
      chk("rel_pos", 400'(mh * 1000 + mv), 400'(1000));
      chk("rel_addr", 400'(ADDR), 400'(1));

      run_to(HV - 1, 0);
      chk("row_end", 400'(ADDR), 400'(HV - 1));
      run_to(HT - 1, 0);
      chk("row_hold", 400'(ADDR), 400'(HV - 1));
      step(24'($urandom));
      chk("row1", 400'(ADDR), 400'(HV));

      run_to(5, 4);
      f2 = rand400();
      field_next = f2;
      step(24'($urandom));
      chk("field_stable", field, 400'(0));

      run_to(HV - 1, VV - 1);
      chk("last_addr", 400'(ADDR), 400'(HV * VV - 1));
      run_to(0, VV);
      chk("field_upd", field, f2);
      chk("done_set", 400'(frame_done), 400'(1));
      step(24'($urandom));
      chk("done_clr", 400'(frame_done), 400'(0));

      run_to(0, VV + 1);
      f3 = rand400();
      field_next = f3;
      run_to(HT - 1, VT - 1);
      chk("blank_hold", 400'(ADDR), 400'(HV * VV - 1));
      step(24'($urandom));
      chk("wrap_addr", 400'(ADDR), 400'(0));
      chk("field_keep", field, f2);

      run_to(3, 2);
      step(24'hb47c3c);
      chk("col_r", 400'(VGA_R), 400'(8'h3c));
      chk("col_g", 400'(VGA_G), 400'(8'h7c));
      chk("col_b", 400'(VGA_B), 400'(8'hb4));
      chk("col_bn", 400'(VGA_BLANK_N), 400'(1));
      run_to(HV + 1, 2);
      step(24'hb47c3c);
      chk("blk_rgb", 400'({VGA_R, VGA_G, VGA_B}), 400'(0));
      chk("blk_bn", 400'(VGA_BLANK_N), 400'(0));

      run_to(0, VV);
      chk("field_upd2", field, f3);
      run_to(5, VV + VFP + VS);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
